// File: rtl/usp_sched_pkg.sv
// Shared types and defaults for the USP request scheduler.
package usp_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic KIND_REG  = 1'b0;
  localparam logic KIND_AUTH = 1'b1;

  localparam int TIMEOUT_CYC_DEF = 16;
  localparam int MAX_RETRY_DEF   = 1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_REQ) sum -= N_REQ;
    return sum[IDX_W-1:0];
  endfunction

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    idx = '0;
    any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[wrap_add(rr_ptr, k)]) begin
        idx = wrap_add(rr_ptr, k);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usp_req_scheduler.sv
// Round-robin scheduler sharing the USP verify/registration datapath among N_REQ requesters,
// with timeout/retry, per-requester response pulses and a registration bitmap.
module usp_req_scheduler
  import usp_sched_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int IDX_W       = $clog2(N_REQ),
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int MAX_RETRY   = MAX_RETRY_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_kind,
  output logic [N_REQ-1:0] gnt,
  output logic             usp_start,
  output logic             usp_kind,
  output logic [IDX_W-1:0] usp_sel,
  input  logic             usp_done,
  input  logic             usp_pass,
  output logic [N_REQ-1:0] rsp_valid,
  output logic             rsp_pass,
  output logic             rsp_timeout,
  output logic [N_REQ-1:0] reg_map,
  output logic             busy
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  state_t           state;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] rr_ptr;
  logic             kind_q;
  logic             rej_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic [RTY_W-1:0] retry_cnt;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             pick_kind;
  logic             pick_rej;

  rr_pick #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_rr_pick (
    .req   (req),
    .rr_ptr(rr_ptr),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // An auth from an unregistered requester is answered locally, never reaching the USP.
  assign pick_kind = req_kind[pick_idx];
  assign pick_rej  = (pick_kind == KIND_AUTH) && !reg_map[pick_idx];

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx_q       <= '0;
      rr_ptr      <= '0;
      kind_q      <= 1'b0;
      rej_q       <= 1'b0;
      tmo_cnt     <= '0;
      retry_cnt   <= '0;
      gnt         <= '0;
      usp_start   <= 1'b0;
      usp_kind    <= 1'b0;
      usp_sel     <= '0;
      rsp_valid   <= '0;
      rsp_pass    <= 1'b0;
      rsp_timeout <= 1'b0;
      reg_map     <= '0;
      busy        <= 1'b0;
    end else begin
      usp_start <= 1'b0;
      rsp_valid <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            idx_q     <= pick_idx;
            kind_q    <= pick_kind;
            rej_q     <= pick_rej;
            gnt       <= onehot(pick_idx);
            usp_sel   <= pick_idx;
            usp_kind  <= pick_kind;
            usp_start <= !pick_rej;
            busy      <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tmo_cnt <= '0;
          if (rej_q) begin
            rsp_valid   <= onehot(idx_q);
            rsp_pass    <= 1'b0;
            rsp_timeout <= 1'b0;
            state       <= ST_RESP;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A completion on the final timeout cycle takes priority over the timeout.
          if (usp_done) begin
            rsp_valid   <= onehot(idx_q);
            rsp_pass    <= usp_pass;
            rsp_timeout <= 1'b0;
            state       <= ST_RESP;
          end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
            if (retry_cnt < RTY_W'(MAX_RETRY)) begin
              retry_cnt <= retry_cnt + 1'b1;
              usp_start <= 1'b1;
              state     <= ST_ISSUE;
            end else begin
              rsp_valid   <= onehot(idx_q);
              rsp_pass    <= 1'b0;
              rsp_timeout <= 1'b1;
              state       <= ST_RESP;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (kind_q == KIND_REG && rsp_pass) reg_map[idx_q] <= 1'b1;
          rr_ptr    <= (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
          retry_cnt <= '0;
          gnt       <= '0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/usp_req_scheduler.md
Name: usp_req_scheduler

Overview:
- Round-robin scheduler that shares the single USP verify/registration datapath among N_REQ requesters (EVs and CSs).
- Serialises register and auth transactions and issues one USP start per transaction.
- Waits for USP completion, with a timeout and bounded retry, then returns a per-requester response pulse.
- Tracks a registration bitmap: an auth from an unregistered requester is rejected locally, without using the USP.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- IDX_W, $clog2(N_REQ), width of the requester index.
- TIMEOUT_CYC, 16, number of WAIT cycles without usp_done before a timeout.
- MAX_RETRY, 1, number of re-issues after a timeout before failing.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- req  in  N_REQ  per-requester request level, held until its rsp_valid
- req_kind  in  N_REQ  per-requester kind: 0=register, 1=auth
- gnt  out  N_REQ  one-hot grant, high ISSUE through RESP
- usp_start  out  1  one-cycle start pulse to USP
- usp_kind  out  1  kind of the granted transaction
- usp_sel  out  IDX_W  index of the granted requester
- usp_done  in  1  USP completion pulse
- usp_pass  in  1  USP result, valid with usp_done
- rsp_valid  out  N_REQ  one-hot, one-cycle response pulse
- rsp_pass  out  1  result, valid with rsp_valid
- rsp_timeout  out  1  retries exhausted, valid with rsp_valid
- reg_map  out  N_REQ  registered-requester bitmap
- busy  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE, rr_ptr=0, reg_map=0, counters 0.
- All outputs are registered.

State machine, states IDLE, ISSUE, WAIT, RESP:
- IDLE:
  - If req != 0, select the first set bit searching upward from rr_ptr with wrap-around.
  - Latch idx, the kind bit and a local-reject flag (kind=1 && !reg_map[idx]).
  - Go to ISSUE.
- ISSUE, one cycle:
  - gnt[idx]=1; usp_sel=idx; usp_kind=kind.
  - usp_start=1 unless local-reject. On local-reject, go to RESP with pass=0, timeout=0.
  - Otherwise clear tmo_cnt and go to WAIT.
- WAIT:
  - usp_done=1: latch usp_pass, go to RESP.
  - tmo_cnt==TIMEOUT_CYC-1 and retry_cnt<MAX_RETRY: retry_cnt++, go to ISSUE (re-pulses usp_start).
  - tmo_cnt==TIMEOUT_CYC-1 and retries exhausted: pass=0, timeout=1, go to RESP.
  - Otherwise tmo_cnt++.
- RESP, one cycle:
  - rsp_valid[idx]=1, with rsp_pass and rsp_timeout.
  - Register kind with pass=1: set reg_map[idx].
  - Auth never changes reg_map. A failed register leaves reg_map unchanged.
  - rr_ptr = idx+1 mod N_REQ; retry_cnt=0; gnt cleared on exit; go to IDLE.

Latency:
- req sampled in IDLE at cycle t gives usp_start at t+1.
- rsp_valid appears 1 cycle after the usp_done sample.
- Local reject: rsp_valid at t+2.
- Minimum turnaround: one IDLE cycle between transactions.

Boundary conditions:
- usp_done in the same cycle as the timeout: done wins.
- usp_done outside WAIT is ignored.
- req[idx] dropping mid-transaction: the transaction completes and rsp_valid still pulses.
- req changes outside IDLE have no effect until the next IDLE.
- Only one transaction is in flight; there is no queueing beyond the req levels.
- rr_ptr wraps N_REQ-1 to 0.
- Repeat register of an already-registered requester goes through the USP normally.
- Reset mid-transaction returns everything to reset values immediately, with no rsp pulse.

Decomposition:
- Shared package usp_sched_pkg holds:
  - state encoding: IDLE=0, ISSUE=1, WAIT=2, RESP=3;
  - KIND_REG=0 and KIND_AUTH=1;
  - defaults for TIMEOUT_CYC and MAX_RETRY.
- One natural sub-module, rr_pick:
  - combinational round-robin priority picker;
  - inputs req and rr_ptr; outputs idx and any.

Test Plan:
- req=4'b0001, kind=0; usp_done+usp_pass after 3 cycles -> usp_start at t+1 with usp_sel=0; rsp_valid=4'b0001, rsp_pass=1; reg_map=4'b0001.
- req=4'b0010, kind=1, requester unregistered -> no usp_start; rsp_valid=4'b0010 at t+2, rsp_pass=0, rsp_timeout=0.
- req=4'b1111, all kind=0, USP acks each after 2 cycles -> grant order 0,1,2,3; then with rr_ptr=1 and req=4'b1001, requester 3 is granted before 0.
- Registered requester 2 auth, USP silent -> usp_start pulses twice, 16 WAIT cycles apart; rsp_valid=4'b0100, rsp_pass=0, rsp_timeout=1.
- usp_done=1 on the same cycle as tmo_cnt=15 -> pass latched; no retry; rsp_timeout=0.
- Assert reset during WAIT -> gnt=0, busy=0, reg_map=0 immediately; no rsp_valid pulse.
